fp16_mul_arbiter: RTL and testbench

Round-robin scheduler that shares one half-precision multiplier unit (`mult16`-style: registered, one-cycle, `en`/`output_ready` interface) among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one multiply per cycle. Each result is tagged with its requester ID and returned through a small result FIFO with backpressure. It sits between the FP_Units multiplier and the compute lanes that share it.

---
 rtl/fp_units_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/fp16_mul_arbiter.sv | 134 +++++++++++++
 tb/tb_fp16_mul_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_units_pkg.sv
// Shared FP_Units definitions: half-precision constants and the tagged
// response record carried through the multiplier arbiter's result FIFO.
package fp_units_pkg;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_QNAN = 16'hFE00;

    // Tag field sized for the largest supported requester count (16).
    localparam int RSP_ID_W = 4;

    typedef struct packed {
        logic [RSP_ID_W-1:0] id;
        logic [FP16_W-1:0]   z;
    } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr
// (with wrap); ptr moves past the winner whenever the grant is consumed.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic                     advance,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  gnt_id
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr;
    logic          found;
    int            idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Shares one registered fp16 multiplier among NREQ requesters; results come
// back tagged with the requester ID through a small backpressured FIFO.
module fp16_mul_arbiter
    import fp_units_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int ID_W      = $clog2(NREQ),
    parameter int RSP_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [FP16_W*NREQ-1:0]   req_a,
    input  logic [FP16_W*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     mul_en,
    output logic [FP16_W-1:0]        mul_a,
    output logic [FP16_W-1:0]        mul_b,
    input  logic [FP16_W-1:0]        mul_z,
    input  logic                     mul_ready,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [FP16_W-1:0]        rsp_z,
    input  logic                     rsp_ready,
    output logic                     err
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic [NREQ-1:0]          gnt;
    logic [$clog2(NREQ)-1:0]  arb_id;
    logic                     issue;
    logic [FP16_W-1:0]        sel_a;
    logic [FP16_W-1:0]        sel_b;

    logic                     inflight_q;
    logic [ID_W-1:0]          tag_q;
    rsp_t                     mem [RSP_DEPTH];
    rsp_t                     wr_data;
    rsp_t                     head;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         fifo_count;
    logic                     push;
    logic                     pop;

    // Space check ignores a same-cycle pop so the grant path stays short.
    assign issue = rst && (|req_valid)
                   && ((int'(fifo_count) + int'(inflight_q)) < RSP_DEPTH);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (issue),
        .gnt     (gnt),
        .gnt_id  (arb_id)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[FP16_W*i +: FP16_W];
                sel_b = req_b[FP16_W*i +: FP16_W];
            end
        end
    end

    assign req_ready = issue ? gnt : '0;
    assign mul_en    = issue;
    assign mul_a     = issue ? sel_a : '0;
    assign mul_b     = issue ? sel_b : '0;

    assign push      = inflight_q & mul_ready;
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;

    always_comb begin
        wr_data               = '0;
        wr_data.id[ID_W-1:0]  = tag_q;
        wr_data.z             = mul_z;
    end

    assign head   = mem[rd_ptr];
    assign rsp_id = rsp_valid ? head.id[ID_W-1:0] : '0;
    assign rsp_z  = rsp_valid ? head.z : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            tag_q      <= '0;
            err        <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                tag_q <= ID_W'(arb_id);
            end
            if (inflight_q && !mul_ready) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Self-checking bench for fp16_mul_arbiter: directed vectors and corner
// sequences plus randomized traffic scored against a queue-based model.
module tb_fp16_mul_arbiter;
    import fp_units_pkg::*;

    localparam int NREQ      = 4;
    localparam int ID_W      = 2;
    localparam int RSP_DEPTH = 4;

    logic                    clk;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [16*NREQ-1:0]      req_a;
    logic [16*NREQ-1:0]      req_b;
    logic [NREQ-1:0]         req_ready;
    logic                    mul_en;
    logic [15:0]             mul_a;
    logic [15:0]             mul_b;
    logic [15:0]             mul_z;
    logic                    mul_ready;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [15:0]             rsp_z;
    logic                    rsp_ready;
    logic                    err;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic suppress;
    logic mon_en;

    typedef struct {
        int          id;
        logic [15:0] z;
        int          cyc;
    } exp_t;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] z;
    } vec_t;

    exp_t            exp_q[$];
    int              m_ptr;
    int              cyc;
    logic [NREQ-1:0] accepted;

    fp16_mul_arbiter #(
        .NREQ(NREQ), .ID_W(ID_W), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_z     (mul_z),
        .mul_ready (mul_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_ready (rsp_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference half-precision multiply (subnormals flushed, truncating).
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          ea, eb, e;
        logic [21:0] p;
        logic [9:0]  m;
        bit          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s      = a[15] ^ b[15];
        ea     = a[14:10];
        eb     = b[14:10];
        a_nan  = (ea == 31) && (a[9:0] != 0);
        b_nan  = (eb == 31) && (b[9:0] != 0);
        a_inf  = (ea == 31) && (a[9:0] == 0);
        b_inf  = (eb == 31) && (b[9:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FP16_QNAN;
        if (a_inf || b_inf) return {s, 5'h1F, 10'h000};
        if (a_zero || b_zero) return {s, 15'h0000};
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = ea + eb - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        if (e >= 31) return {s, 5'h1F, 10'h000};
        if (e <= 0) return {s, 15'h0000};
        return {s, e[4:0], m};
    endfunction

    function automatic void check_output(input string name, input logic [31:0] act,
                                         input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic apply_stimulus(input int id, input logic [15:0] a, input logic [15:0] b);
        req_valid[id]     = 1'b1;
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
    endtask

    // Registered one-cycle multiplier with an optional dropped output_ready.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_z     <= '0;
            mul_ready <= 1'b0;
        end else begin
            mul_z     <= fp16_mul(mul_a, mul_b);
            mul_ready <= mul_en & ~suppress;
        end
    end

    // Scoreboard: outstanding results = accepted but not yet popped.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_gnt;
        logic            exp_issue;
        logic            vis;
        int              g;
        exp_gnt  = '0;
        accepted = '0;
        if (rst_n && mon_en) begin
            exp_issue = (|req_valid) && (exp_q.size() < RSP_DEPTH);
            g = -1;
            if (exp_issue) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
                exp_gnt[g] = 1'b1;
            end
            check_output("mon_req_ready", 32'(req_ready), 32'(exp_gnt));
            check_output("mon_mul_en", 32'(mul_en), 32'(exp_issue));
            vis = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc - 2);
            check_output("mon_rsp_valid", 32'(rsp_valid), 32'(vis));
            if (vis) begin
                check_output("mon_rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                check_output("mon_rsp_z", 32'(rsp_z), 32'(exp_q[0].z));
                if (rsp_ready) void'(exp_q.pop_front());
            end
            if (exp_issue) begin
                exp_q.push_back('{g, fp16_mul(req_a[16*g +: 16], req_b[16*g +: 16]), cyc});
                m_ptr    = (g + 1) % NREQ;
                accepted = exp_gnt;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            assert (dut.fifo_count <= RSP_DEPTH)
            else $error("[TB] result fifo count exceeds depth");
        end
    end

    initial begin
        vec_t            vec [4];
        logic [NREQ-1:0] oh;
        int              exp_order [5];
        int              issues;
        int              got;

        vec[0] = '{2, 16'h3C00, 16'h4000, 16'h4000};
        vec[1] = '{0, 16'h4200, 16'h4400, 16'h4A00};
        vec[2] = '{1, 16'h7C00, 16'h0000, 16'hFE00};
        vec[3] = '{3, 16'hC000, 16'h3800, 16'hBC00};
        exp_order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        suppress = 1'b0; mon_en = 1'b1; m_ptr = 0; cyc = 0;
        #2;
        check_output("reset_req_ready", 32'(req_ready), 0);
        check_output("reset_mul_en", 32'(mul_en), 0);
        check_output("reset_mul_ab", {mul_a, mul_b}, 0);
        check_output("reset_rsp", {13'h0, rsp_valid, rsp_id, rsp_z}, 0);
        check_output("reset_err", 32'(err), 0);

        @(posedge clk); #1;
        rst_n = 1'b1; rsp_ready = 1'b1;

        $display("[TB] single-request vectors");
        for (int v = 0; v < 4; v++) begin
            @(posedge clk); #1;
            req_valid = '0;
            apply_stimulus(vec[v].id, vec[v].a, vec[v].b);
            oh = '0;
            oh[vec[v].id] = 1'b1;
            @(negedge clk);
            check_output("vec_grant", 32'(req_ready), 32'(oh));
            check_output("vec_mul_ab", {mul_a, mul_b}, {vec[v].a, vec[v].b});
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            check_output("vec_mul_en_one_cycle", 32'(mul_en), 0);
            check_output("vec_rsp_early", 32'(rsp_valid), 0);
            @(negedge clk);
            check_output("vec_rsp_valid", 32'(rsp_valid), 1);
            check_output("vec_rsp_id", 32'(rsp_id), 32'(vec[v].id));
            check_output("vec_rsp_z", 32'(rsp_z), 32'(vec[v].z));
            check_output("vec_err", 32'(err), 0);
            @(negedge clk);
            check_output("vec_rsp_popped", 32'(rsp_valid), 0);
        end

        $display("[TB] all requesters back-to-back");
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) apply_stimulus(i, 16'h3C00 + 16'(i * 16'h0400), 16'h4000);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 5) begin
                oh = '0;
                oh[exp_order[k]] = 1'b1;
                check_output("rr_grant", 32'(req_ready), 32'(oh));
            end
            if (k >= 2) begin
                check_output("rr_rsp_valid", 32'(rsp_valid), 1);
                check_output("rr_rsp_id", 32'(rsp_id), 32'(exp_order[k-2]));
            end
            @(posedge clk); #1;
            if (k == 4) req_valid = '0;
        end
        repeat (3) @(posedge clk);

        $display("[TB] backpressure");
        #1;
        rsp_ready = 1'b0;
        apply_stimulus(0, 16'h4200, 16'h4400);
        issues = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready[0]) issues++;
            @(posedge clk); #1;
        end
        check_output("bp_issue_count", 32'(issues), RSP_DEPTH);
        @(negedge clk);
        check_output("bp_ready_low", 32'(req_ready), 0);
        @(posedge clk); #1;
        req_valid = '0; rsp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                check_output("bp_drain_id", 32'(rsp_id), 0);
                check_output("bp_drain_z", 32'(rsp_z), 32'h4A00);
                got++;
            end
        end
        check_output("bp_drain_count", 32'(got), RSP_DEPTH);

        $display("[TB] dropped mul_ready");
        @(posedge clk); #1;
        mon_en = 1'b0; suppress = 1'b1;
        apply_stimulus(1, 16'h3C00, 16'h3C00);
        @(negedge clk);
        check_output("err_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0; suppress = 1'b0;
        @(negedge clk);
        check_output("err_not_yet", 32'(err), 0);
        @(negedge clk);
        check_output("err_set", 32'(err), 1);
        check_output("err_no_push", 32'(rsp_valid), 0);
        repeat (3) @(negedge clk);
        check_output("err_no_push_later", 32'(rsp_valid), 0);

        $display("[TB] reset mid-operation");
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        apply_stimulus(2, 16'h3C00, 16'h3C00);
        issues = 0;
        for (int k = 0; k < 20 && issues < RSP_DEPTH; k++) begin
            @(negedge clk);
            if (req_ready[2]) issues++;
            if (issues < RSP_DEPTH) begin
                @(posedge clk); #1;
            end
        end
        check_output("rst_fill_issues", 32'(issues), RSP_DEPTH);
        @(posedge clk); #1;
        check_output("err_sticky", 32'(err), 1);
        check_output("rst_pre_valid", 32'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        check_output("rst_async_req_ready", 32'(req_ready), 0);
        check_output("rst_async_mul", {15'h0, mul_en, mul_a}, 0);
        check_output("rst_async_mul_b", 32'(mul_b), 0);
        check_output("rst_async_rsp", {13'h0, rsp_valid, rsp_id, rsp_z}, 0);
        check_output("rst_async_err", 32'(err), 0);
        exp_q.delete();
        m_ptr = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output("rst_rsp_empty", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
        apply_stimulus(0, 16'h4000, 16'h4000);
        apply_stimulus(2, 16'h4400, 16'h3800);
        @(negedge clk);
        check_output("rst_first_grant", 32'(req_ready), 32'h1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || accepted[i]) begin
                    req_valid[i]      = ($urandom_range(0, 99) < 55);
                    req_a[16*i +: 16] = 16'($urandom);
                    req_b[16*i +: 16] = 16'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
        end
        @(posedge clk); #1;
        req_valid = '0; rsp_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check_output("drain_model_empty", 32'(exp_q.size()), 0);
        check_output("drain_rsp_valid", 32'(rsp_valid), 0);
        check_output("final_err", 32'(err), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
